vblank_frame_pacer: RTL

Frame-pacing block in the `clk` (100 MHz) domain that closes the loop from the VGA side back to the game side. It synchronizes the VGA vertical sync, issues one game-update tick per displayed frame, and tracks whether the game update completed before the next vertical blank. It also holds `publish_en` high only while game state is stable. The VGA-domain snapshot register captures game data during vblank, so this guarantees that every captured frame is complete and was updated exactly once.

---
 rtl/vblank_frame_pacer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vblank_frame_pacer.sv
// vblank_frame_pacer: paces game updates from the VGA vertical sync.
// Synchronizes the raw VS, turns each falling edge into a frame event and
// sequences IDLE -> UPDATING -> READY, issuing one frame_tick per frame.
// publish_en is high only while the game state is complete (READY).
// Optional feature macro: VBLANK_FRAME_PACER_WATCHDOG_EN adds a VS-loss
// watchdog that injects synthetic frame events every TIMEOUT_CYCLES cycles.
`timescale 1ns/1ps

module vblank_frame_pacer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1_700_000
) (
    input  logic        clk,
    input  logic        rst_n_debounced,
    input  logic        vs_in,
    input  logic        upd_done,
    output logic        frame_tick,
    output logic        publish_en,
    output logic [15:0] frame_cnt,
    output logic [7:0]  overrun_cnt,
    output logic        vs_lost
);

    localparam int unsigned FRAME_CNT_W   = 16;
    localparam int unsigned OVERRUN_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UPDATING = 2'd1,
        READY    = 2'd2
    } state_e;

    // Reject parameter values the synchronizer and watchdog cannot honour
    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("vblank_frame_pacer: SYNC_STAGES and TIMEOUT_CYCLES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] vs_sync_q, vs_sync_d;
    logic                   vs_hist_q, vs_hist_d;
    logic                   ev_real_c;
    logic                   wd_hit_c;
    logic                   ev_c;

    state_e                   state_q, state_d;
    logic                     frame_tick_q, frame_tick_d;
    logic                     publish_en_q, publish_en_d;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [OVERRUN_CNT_W-1:0] overrun_cnt_q, overrun_cnt_d;
    logic                     vs_lost_q, vs_lost_d;

    // Shift VS into the synchronizer; history flop trails the last stage
    always_comb begin
        vs_sync_d = {vs_sync_q[SYNC_STAGES-2:0], vs_in};
        vs_hist_d = vs_sync_q[SYNC_STAGES-1];
    end

    // Synchronizer flops idle high so reset release never looks like an edge
    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            vs_sync_q <= '1;
            vs_hist_q <= 1'b1;
        end else begin
            vs_sync_q <= vs_sync_d;
            vs_hist_q <= vs_hist_d;
        end
    end

    // Falling edge of synchronized VS marks the start of vblank
    assign ev_real_c = vs_hist_q & ~vs_sync_q[SYNC_STAGES-1];

`ifdef VBLANK_FRAME_PACER_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    assign wd_hit_c = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog restarts on every real edge and on its own timeout
    always_comb begin
        wd_cnt_d  = wd_cnt_q + WD_W'(1);
        vs_lost_d = vs_lost_q;
        if (ev_real_c || wd_hit_c) begin
            wd_cnt_d = '0;
        end
        if (ev_real_c) begin
            vs_lost_d = 1'b0;
        end else if (wd_hit_c) begin
            vs_lost_d = 1'b1;
        end
    end

    // Watchdog cycle counter
    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_hit_c  = 1'b0;
    assign vs_lost_d = 1'b0;
`endif

    // Real and synthetic events are handled identically by the FSM
    assign ev_c = ev_real_c | wd_hit_c;

    // Next-state and output logic for the pacing FSM
    always_comb begin
        state_d       = state_q;
        frame_tick_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        overrun_cnt_d = overrun_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (ev_c) begin
                    state_d      = UPDATING;
                    frame_tick_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
                end
            end
            UPDATING: begin
                if (ev_c && upd_done) begin
                    // Done and edge together: accept the done, start next frame
                    frame_tick_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
                end else if (ev_c) begin
                    // Update missed this vblank: keep waiting, count the miss
                    if (overrun_cnt_q != '1) begin
                        overrun_cnt_d = overrun_cnt_q + OVERRUN_CNT_W'(1);
                    end
                end else if (upd_done) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (ev_c) begin
                    state_d      = UPDATING;
                    frame_tick_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        publish_en_d = (state_d == READY);
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            state_q       <= IDLE;
            frame_tick_q  <= 1'b0;
            publish_en_q  <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_cnt_q <= '0;
            vs_lost_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_tick_q  <= frame_tick_d;
            publish_en_q  <= publish_en_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
            vs_lost_q     <= vs_lost_d;
        end
    end

    assign frame_tick  = frame_tick_q;
    assign publish_en  = publish_en_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_cnt_q;
    assign vs_lost     = vs_lost_q;

endmodule
